// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: register addresses and write enables in,
// stall/flush/forward controls and performance counters out.
interface hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E;
  logic [REG_AW-1:0] Rd_E, Rd_M, Rd_W;
  logic              regWrite_E, regWrite_M, regWrite_W;
  logic [1:0]        resultSrc_E;
  logic              PCsrc_E;
  logic              cnt_en, cnt_clr;
  logic              stall_F, stall_D, flush_D, flush_E;
  logic [1:0]        forwardA_E, forwardB_E;
  logic [CNT_W-1:0]  cycle_cnt, stall_cnt, flush_cnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
           regWrite_E, regWrite_M, regWrite_W, resultSrc_E, PCsrc_E,
           cnt_en, cnt_clr,
    input  stall_F, stall_D, flush_D, flush_E, forwardA_E, forwardB_E,
           cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
           regWrite_E, regWrite_M, regWrite_W, resultSrc_E, PCsrc_E,
           cnt_en, cnt_clr,
    output stall_F, stall_D, flush_D, flush_E, forwardA_E, forwardB_E,
           cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage pipeline hazard unit: combinational forward/stall/flush control
// plus saturating cycle, stall and flush counters.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input logic      clk,
  input logic      rst,
  hazard_unit_if.slave hz
);

  function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] src);
    return we && (rd == src) && (rd != '0);
  endfunction

  logic       hazard;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    hazard = 1'b0;
    if (FWD_EN) begin
      if (hit(hz.regWrite_M, hz.Rd_M, hz.Rs1_E))      fwd_a = 2'b10;
      else if (hit(hz.regWrite_W, hz.Rd_W, hz.Rs1_E)) fwd_a = 2'b01;
      if (hit(hz.regWrite_M, hz.Rd_M, hz.Rs2_E))      fwd_b = 2'b10;
      else if (hit(hz.regWrite_W, hz.Rd_W, hz.Rs2_E)) fwd_b = 2'b01;
      hazard = (hz.resultSrc_E == 2'b01) &&
               (hit(hz.regWrite_E, hz.Rd_E, hz.Rs1_D) ||
                hit(hz.regWrite_E, hz.Rd_E, hz.Rs2_D));
    end else begin
      // Interlock-only: any in-flight writer of a decode source blocks issue
      // until it has left W.
      hazard = hit(hz.regWrite_E, hz.Rd_E, hz.Rs1_D) || hit(hz.regWrite_E, hz.Rd_E, hz.Rs2_D) ||
               hit(hz.regWrite_M, hz.Rd_M, hz.Rs1_D) || hit(hz.regWrite_M, hz.Rd_M, hz.Rs2_D) ||
               hit(hz.regWrite_W, hz.Rd_W, hz.Rs1_D) || hit(hz.regWrite_W, hz.Rd_W, hz.Rs2_D);
    end
  end

  always_comb begin
    hz.stall_F    = 1'b0;
    hz.stall_D    = 1'b0;
    hz.flush_D    = 1'b0;
    hz.flush_E    = 1'b0;
    hz.forwardA_E = fwd_a;
    hz.forwardB_E = fwd_b;
    if (rst) begin
      hz.flush_D    = 1'b1;
      hz.flush_E    = 1'b1;
      hz.forwardA_E = 2'b00;
      hz.forwardB_E = 2'b00;
    end else if (hz.PCsrc_E) begin
      // Wrong-path instruction in D: squash rather than hold it.
      hz.flush_D = 1'b1;
      hz.flush_E = 1'b1;
    end else if (hazard) begin
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.flush_E = 1'b1;
    end
  end

  // Counter order: 0 = cycle, 1 = stall, 2 = flush.
  logic [2:0]            inc;
  logic [2:0][CNT_W-1:0] cnt;

  assign inc = {hz.PCsrc_E, hz.stall_D, 1'b1} & {3{hz.cnt_en}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || hz.cnt_clr)             cnt[i] <= '0;
      else if (inc[i] && cnt[i] != '1)   cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign hz.cycle_cnt = cnt[0];
  assign hz.stall_cnt = cnt[1];
  assign hz.flush_cnt = cnt[2];

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, branch flush,
// interlock mode, counter saturation/clear and reset override.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(5), .CNT_W(32)) f_if();
  hazard_unit_if #(.REG_AW(5), .CNT_W(32)) s_if();
  hazard_unit_if #(.REG_AW(5), .CNT_W(4))  q_if();

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)) u_f (.clk(clk), .rst(rst), .hz(f_if.slave));
  hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(32)) u_s (.clk(clk), .rst(rst), .hz(s_if.slave));
  hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(4))  u_q (.clk(clk), .rst(rst), .hz(q_if.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {f_if.Rs1_D, f_if.Rs2_D, f_if.Rs1_E, f_if.Rs2_E, f_if.Rd_E, f_if.Rd_M, f_if.Rd_W,
     f_if.regWrite_E, f_if.regWrite_M, f_if.regWrite_W, f_if.resultSrc_E, f_if.PCsrc_E,
     f_if.cnt_en, f_if.cnt_clr} = '0;
    {s_if.Rs1_D, s_if.Rs2_D, s_if.Rs1_E, s_if.Rs2_E, s_if.Rd_E, s_if.Rd_M, s_if.Rd_W,
     s_if.regWrite_E, s_if.regWrite_M, s_if.regWrite_W, s_if.resultSrc_E, s_if.PCsrc_E,
     s_if.cnt_en, s_if.cnt_clr} = '0;
    {q_if.Rs1_D, q_if.Rs2_D, q_if.Rs1_E, q_if.Rs2_E, q_if.Rd_E, q_if.Rd_M, q_if.Rd_W,
     q_if.regWrite_E, q_if.regWrite_M, q_if.regWrite_W, q_if.resultSrc_E, q_if.PCsrc_E,
     q_if.cnt_en, q_if.cnt_clr} = '0;

    // Reset overrides a live forwarding match and counting
    f_if.Rd_M = 5'd5; f_if.regWrite_M = 1'b1;
    f_if.Rd_W = 5'd5; f_if.regWrite_W = 1'b1;
    f_if.Rs1_E = 5'd5; f_if.cnt_en = 1'b1;
    #1;
    chk("rst_fwdA", f_if.forwardA_E, 2'b00);
    chk("rst_flushD", f_if.flush_D, 1'b1);
    chk("rst_flushE", f_if.flush_E, 1'b1);
    chk("rst_stallF", f_if.stall_F, 1'b0);
    step();
    chk("rst_cycle_cnt", f_if.cycle_cnt, 0);
    rst = 1'b0;
    f_if.cnt_en = 1'b0;

    // Forwarding priority M over W
    #1;
    chk("fwdA_M", f_if.forwardA_E, 2'b10);
    chk("flushD_idle", f_if.flush_D, 1'b0);
    f_if.regWrite_M = 1'b0; #1;
    chk("fwdA_W", f_if.forwardA_E, 2'b01);
    f_if.Rs2_E = 5'd5; #1;
    chk("fwdB_W", f_if.forwardB_E, 2'b01);
    f_if.Rd_W = 5'd0; f_if.Rs1_E = 5'd0; #1;
    chk("fwdA_x0", f_if.forwardA_E, 2'b00);
    f_if.Rd_W = 5'd0; f_if.regWrite_W = 1'b0; f_if.Rs2_E = 5'd0; f_if.Rd_M = 5'd0;

    // Load-use: one stall cycle then load advances to M
    f_if.cnt_clr = 1'b1; step(); f_if.cnt_clr = 1'b0; f_if.cnt_en = 1'b1;
    f_if.Rd_E = 5'd3; f_if.resultSrc_E = 2'b01; f_if.regWrite_E = 1'b1; f_if.Rs2_D = 5'd3;
    #1;
    chk("lu_stallF", f_if.stall_F, 1'b1);
    chk("lu_stallD", f_if.stall_D, 1'b1);
    chk("lu_flushE", f_if.flush_E, 1'b1);
    chk("lu_flushD", f_if.flush_D, 1'b0);
    step();
    f_if.Rd_E = 5'd0; f_if.resultSrc_E = 2'b00; f_if.regWrite_E = 1'b0;
    f_if.Rd_M = 5'd3; f_if.regWrite_M = 1'b1;
    #1;
    chk("lu_release", f_if.stall_D, 1'b0);
    chk("lu_stall_cnt", f_if.stall_cnt, 1);
    chk("lu_flush_cnt", f_if.flush_cnt, 0);

    // Load-use coinciding with a taken branch: flush wins
    f_if.Rd_M = 5'd0; f_if.regWrite_M = 1'b0;
    f_if.cnt_clr = 1'b1; step(); f_if.cnt_clr = 1'b0;
    f_if.Rd_E = 5'd3; f_if.resultSrc_E = 2'b01; f_if.regWrite_E = 1'b1; f_if.PCsrc_E = 1'b1;
    #1;
    chk("br_flushD", f_if.flush_D, 1'b1);
    chk("br_flushE", f_if.flush_E, 1'b1);
    chk("br_stallF", f_if.stall_F, 1'b0);
    chk("br_stallD", f_if.stall_D, 1'b0);
    step();
    chk("br_flush_cnt", f_if.flush_cnt, 1);
    chk("br_stall_cnt", f_if.stall_cnt, 0);
    chk("br_cycle_cnt", f_if.cycle_cnt, 1);

    // Reset during an active stall
    f_if.PCsrc_E = 1'b0; #1;
    chk("mid_stallF", f_if.stall_F, 1'b1);
    step();
    chk("mid_stall_cnt", f_if.stall_cnt, 1);
    rst = 1'b1; #1;
    chk("rs_stallF", f_if.stall_F, 1'b0);
    chk("rs_stallD", f_if.stall_D, 1'b0);
    chk("rs_flushD", f_if.flush_D, 1'b1);
    chk("rs_flushE", f_if.flush_E, 1'b1);
    step();
    chk("rs_cycle_cnt", f_if.cycle_cnt, 0);
    chk("rs_stall_cnt", f_if.stall_cnt, 0);
    chk("rs_flush_cnt", f_if.flush_cnt, 0);
    rst = 1'b0;
    f_if.cnt_en = 1'b0;

    // Interlock mode: adjacent producer x7 -> 3 stall cycles
    s_if.cnt_en = 1'b1;
    s_if.Rd_E = 5'd7; s_if.regWrite_E = 1'b1; s_if.Rs1_D = 5'd7; s_if.Rs1_E = 5'd7;
    #1;
    chk("il_stall1", s_if.stall_D, 1'b1);
    chk("il_flushE", s_if.flush_E, 1'b1);
    step();
    s_if.Rd_E = 5'd0; s_if.regWrite_E = 1'b0; s_if.Rd_M = 5'd7; s_if.regWrite_M = 1'b1;
    #1;
    chk("il_stall2", s_if.stall_D, 1'b1);
    chk("il_nofwd", s_if.forwardA_E, 2'b00);
    step();
    s_if.Rd_M = 5'd0; s_if.regWrite_M = 1'b0; s_if.Rd_W = 5'd7; s_if.regWrite_W = 1'b1;
    #1;
    chk("il_stall3", s_if.stall_D, 1'b1);
    step();
    s_if.Rd_W = 5'd0; s_if.regWrite_W = 1'b0;
    #1;
    chk("il_release", s_if.stall_D, 1'b0);
    chk("il_stall_cnt", s_if.stall_cnt, 3);

    // One gap: producer already in M -> 2 stall cycles
    s_if.Rd_M = 5'd7; s_if.regWrite_M = 1'b1;
    step();
    s_if.Rd_M = 5'd0; s_if.regWrite_M = 1'b0; s_if.Rd_W = 5'd7; s_if.regWrite_W = 1'b1;
    step();
    s_if.Rd_W = 5'd0; s_if.regWrite_W = 1'b0;
    #1;
    chk("il_gap_release", s_if.stall_D, 1'b0);
    chk("il_gap_stall_cnt", s_if.stall_cnt, 5);

    // Writer to x0 never interlocks
    s_if.Rd_E = 5'd0; s_if.regWrite_E = 1'b1; s_if.Rs1_D = 5'd0;
    #1;
    chk("il_x0", s_if.stall_D, 1'b0);
    s_if.regWrite_E = 1'b0; s_if.cnt_en = 1'b0;

    // 4-bit counter saturation and clear priority
    q_if.cnt_en = 1'b1;
    repeat (14) step();
    chk("sat_14", q_if.cycle_cnt, 14);
    repeat (6) step();
    chk("sat_15", q_if.cycle_cnt, 15);
    chk("sat_stall_cnt", q_if.stall_cnt, 0);
    q_if.cnt_clr = 1'b1; step();
    chk("sat_clr", q_if.cycle_cnt, 0);
    q_if.cnt_clr = 1'b0; q_if.cnt_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
